// File: rtl/redmule_mx_exp_unpacker.sv
// Receive end of one MX exponent stream: accepts 64-byte beats and unpacks them
// into one shared exponent (or LANES-wide exponent vector) per MX block.
module redmule_mx_exp_unpacker #(
   parameter int unsigned BEAT_W = 512,
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned LANES  = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   start_i,
   input  logic [31:0]            num_blocks_i,
   input  logic                   beat_valid_i,
   output logic                   beat_ready_o,
   input  logic [BEAT_W-1:0]      beat_data_i,
   output logic                   exp_valid_o,
   input  logic                   exp_ready_i,
   output logic [LANES*EXP_W-1:0] exp_data_o,
   output logic                   exp_last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   localparam int unsigned BLK_W    = LANES * EXP_W;
   localparam int unsigned SLOTS    = BEAT_W / BLK_W;
   localparam int unsigned SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [31:0] SLOTS_32 = 32'(SLOTS);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_e;

   state_e              r_state, w_state_next;
   logic [31:0]         r_fetch_left, w_fetch_left_next;
   logic [31:0]         r_emit_left, w_emit_left_next;
   logic [BEAT_W-1:0]   r_buf_data, w_buf_data_next;
   logic                r_buf_valid, w_buf_valid_next;
   logic [SLOT_W-1:0]   r_slot, w_slot_next;
   logic [SLOT_W-1:0]   r_last_slot, w_last_slot_next;
   logic                r_done, w_done_next;

   logic                w_active;
   logic                w_exp_fire;
   logic                w_slot_end;
   logic                w_beat_ready;
   logic                w_beat_fire;
   logic                w_last_fire;
   logic [31:0]         w_take;
   logic [BLK_W-1:0]    w_words [SLOTS];

   // Beat buffer viewed as an array of block-sized words, slot 0 in the LSBs.
   for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign w_words[gi] = r_buf_data[gi*BLK_W +: BLK_W];
   end

   assign w_active     = (r_state == S_ACTIVE);
   assign w_exp_fire   = r_buf_valid && exp_ready_i;
   assign w_slot_end   = (r_slot == r_last_slot);
   assign w_last_fire  = w_exp_fire && (r_emit_left == 32'd1);
   // A refill may land in the same cycle the final buffered slot drains.
   assign w_beat_ready = w_active && (r_fetch_left != 32'd0)
                         && (!r_buf_valid || (w_exp_fire && w_slot_end));
   assign w_beat_fire  = beat_valid_i && w_beat_ready;
   assign w_take       = (r_fetch_left > SLOTS_32) ? SLOTS_32 : r_fetch_left;

   assign beat_ready_o = w_beat_ready;
   assign exp_valid_o  = r_buf_valid;
   assign exp_data_o   = r_buf_valid ? w_words[r_slot] : '0;
   assign exp_last_o   = r_buf_valid && (r_emit_left == 32'd1);
   assign busy_o       = w_active;
   assign done_o       = r_done;

   always_comb begin
      w_state_next      = r_state;
      w_fetch_left_next = r_fetch_left;
      w_emit_left_next  = r_emit_left;
      w_buf_data_next   = r_buf_data;
      w_buf_valid_next  = r_buf_valid;
      w_slot_next       = r_slot;
      w_last_slot_next  = r_last_slot;
      w_done_next       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (num_blocks_i != 32'd0) begin
                  w_state_next      = S_ACTIVE;
                  w_fetch_left_next = num_blocks_i;
                  w_emit_left_next  = num_blocks_i;
               end else begin
                  w_done_next = 1'b1;
               end
            end
         end
         S_ACTIVE: begin
            if (w_exp_fire) begin
               w_emit_left_next = r_emit_left - 32'd1;
               if (w_slot_end) begin
                  w_buf_valid_next = 1'b0;
               end else begin
                  w_slot_next = r_slot + SLOT_W'(1);
               end
            end
            // Evaluated after the drain so a same-cycle refill wins.
            if (w_beat_fire) begin
               w_buf_data_next   = beat_data_i;
               w_buf_valid_next  = 1'b1;
               w_slot_next       = '0;
               w_last_slot_next  = SLOT_W'(w_take - 32'd1);
               w_fetch_left_next = r_fetch_left - w_take;
            end
            if (w_last_fire) begin
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (clear_i) begin
         w_state_next      = S_IDLE;
         w_fetch_left_next = '0;
         w_emit_left_next  = '0;
         w_buf_data_next   = '0;
         w_buf_valid_next  = 1'b0;
         w_slot_next       = '0;
         w_last_slot_next  = '0;
         w_done_next       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_fetch_left <= '0;
         r_emit_left  <= '0;
         r_buf_data   <= '0;
         r_buf_valid  <= 1'b0;
         r_slot       <= '0;
         r_last_slot  <= '0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_fetch_left <= w_fetch_left_next;
         r_emit_left  <= w_emit_left_next;
         r_buf_data   <= w_buf_data_next;
         r_buf_valid  <= w_buf_valid_next;
         r_slot       <= w_slot_next;
         r_last_slot  <= w_last_slot_next;
         r_done       <= w_done_next;
      end
   end

endmodule

// File: tb/tb_redmule_mx_exp_unpacker.sv
// Bench for the MX exponent unpacker: one X-stream (LANES=1) and one W-stream
// (LANES=4) instance, checked cycle by cycle against a block-count model.
module tb_redmule_mx_exp_unpacker;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b1;
   logic         clear = 1'b0;
   logic         start_x = 1'b0;
   logic         start_w = 1'b0;
   logic [31:0]  nblk = '0;
   logic         beat_valid = 1'b0;
   logic [511:0] beat_data = '0;
   logic         exp_ready = 1'b0;

   logic         x_bready, x_evalid, x_elast, x_busy, x_done;
   logic [7:0]   x_edata;
   logic         w_bready, w_evalid, w_elast, w_busy, w_done;
   logic [31:0]  w_edata;

   redmule_mx_exp_unpacker #(.BEAT_W(512), .EXP_W(8), .LANES(1)) u_x (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .start_i(start_x),
      .num_blocks_i(nblk), .beat_valid_i(beat_valid), .beat_ready_o(x_bready),
      .beat_data_i(beat_data), .exp_valid_o(x_evalid), .exp_ready_i(exp_ready),
      .exp_data_o(x_edata), .exp_last_o(x_elast), .busy_o(x_busy), .done_o(x_done));

   redmule_mx_exp_unpacker #(.BEAT_W(512), .EXP_W(8), .LANES(4)) u_w (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .start_i(start_w),
      .num_blocks_i(nblk), .beat_valid_i(beat_valid), .beat_ready_o(w_bready),
      .beat_data_i(beat_data), .exp_valid_o(w_evalid), .exp_ready_i(exp_ready),
      .exp_data_o(w_edata), .exp_last_o(w_elast), .busy_o(w_busy), .done_o(w_done));

   always #5 clk = ~clk;

   int  errors = 0;
   int  checks = 0;
   bit  sel = 1'b0;        // 0: X instance, 1: W instance
   logic [511:0] beats [0:7];
   int  n_offer = 0;
   int  beat_idx = 0;

   bit  m_active = 1'b0;
   bit  m_done_now = 1'b0;
   int  m_nb = 0;
   int  m_fetched = 0;
   int  m_emitted = 0;
   int  m_done_cnt = 0;
   bit  p_stall = 1'b0;
   logic [31:0] p_data = '0;

   logic        o_bready, o_evalid, o_elast, o_busy, o_done;
   logic [31:0] o_edata;
   assign o_bready = sel ? w_bready : x_bready;
   assign o_evalid = sel ? w_evalid : x_evalid;
   assign o_elast  = sel ? w_elast  : x_elast;
   assign o_busy   = sel ? w_busy   : x_busy;
   assign o_done   = sel ? w_done   : x_done;
   assign o_edata  = sel ? w_edata  : {24'h0, x_edata};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Block i lives in beat i/SLOTS at word i%SLOTS.
   function automatic logic [31:0] ref_exp(input int i);
      int slots = sel ? 16 : 64;
      int lw    = sel ? 32 : 8;
      logic [511:0] sh;
      sh = beats[(i / slots) % 8] >> ((i % slots) * lw);
      return sel ? sh[31:0] : {24'h0, sh[7:0]};
   endfunction

   task automatic fill_random(input int n);
      for (int b = 0; b < n; b++)
         for (int w = 0; w < 16; w++)
            beats[b][w*32 +: 32] = $urandom;
   endtask

   task automatic step(input bit do_start, input logic [31:0] nb, input bit do_clear, input bit rdy);
      int unread;
      int slots;
      bit bready_exp, efire, bfire;
      slots = sel ? 16 : 64;
      @(negedge clk);
      clear      = do_clear;
      start_x    = do_start && !sel;
      start_w    = do_start && sel;
      nblk       = nb;
      exp_ready  = rdy;
      beat_valid = (beat_idx < n_offer);
      beat_data  = beat_valid ? beats[beat_idx % 8] : '0;
      #1;
      unread     = m_fetched - m_emitted;
      bready_exp = m_active && (m_fetched < m_nb) && (unread == 0 || (unread == 1 && rdy));
      chk("busy", o_busy, m_active);
      chk("done", o_done, m_done_now);
      chk("exp_valid", o_evalid, unread > 0);
      chk("beat_ready", o_bready, bready_exp);
      if (o_evalid) begin
         chk("exp_data", o_edata, ref_exp(m_emitted));
         chk("exp_last", o_elast, m_emitted == m_nb - 1);
      end
      if (p_stall) chk("stall_stable", o_edata, p_data);
      p_stall = o_evalid && !rdy && !do_clear;
      p_data  = o_edata;
      if (o_done) m_done_cnt++;
      efire = o_evalid && rdy;
      bfire = beat_valid && o_bready;
      m_done_now = 1'b0;
      if (do_clear) begin
         m_active = 1'b0; m_fetched = 0; m_emitted = 0; m_nb = 0;
      end else if (m_active) begin
         if (bfire) begin
            m_fetched = (m_fetched + slots > m_nb) ? m_nb : m_fetched + slots;
            beat_idx++;
         end
         if (efire) begin
            m_emitted++;
            if (m_emitted == m_nb) begin
               m_active = 1'b0;
               m_done_now = 1'b1;
            end
         end
      end else if (do_start) begin
         if (nb != 0) begin
            m_active = 1'b1; m_nb = nb; m_fetched = 0; m_emitted = 0; beat_idx = 0;
         end else begin
            m_done_now = 1'b1;
         end
      end
   endtask

   task automatic run(input int budget, input bit rand_rdy);
      for (int i = 0; i < budget; i++) begin
         if (!m_active && !m_done_now) break;
         step(1'b0, 32'd0, 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      chk("job_timeout", m_active, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   initial begin
      #1 rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_x_bready", x_bready, 0); chk("rst_x_valid", x_evalid, 0);
      chk("rst_x_data", x_edata, 0);    chk("rst_x_last", x_elast, 0);
      chk("rst_x_busy", x_busy, 0);     chk("rst_x_done", x_done, 0);
      chk("rst_w_bready", w_bready, 0); chk("rst_w_valid", w_evalid, 0);
      chk("rst_w_data", w_edata, 0);    chk("rst_w_last", w_elast, 0);
      chk("rst_w_busy", w_busy, 0);     chk("rst_w_done", w_done, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      step(1'b0, 32'd0, 1'b0, 1'b1);

      // X stream, 8 blocks from one beat of bytes 0x10..0x4F
      sel = 1'b0;
      for (int i = 0; i < 64; i++) beats[0][i*8 +: 8] = 8'(8'h10 + i);
      n_offer = 1; m_done_cnt = 0;
      step(1'b1, 32'd8, 1'b0, 1'b1);
      chk("t1_first_exp", ref_exp(0), 32'h10);
      run(40, 1'b0);
      chk("t1_beats", beat_idx, 1);
      chk("t1_emitted", m_emitted, 8);
      chk("t1_done_cnt", m_done_cnt, 1);
      $display("txn t1: X 8 blocks, beats=%0d emitted=%0d", beat_idx, m_emitted);

      // W stream, 20 blocks over two beats with a third beat pending
      sel = 1'b1;
      fill_random(3);
      n_offer = 3; m_done_cnt = 0;
      step(1'b1, 32'd20, 1'b0, 1'b1);
      run(60, 1'b0);
      chk("t2_beats", beat_idx, 2);
      chk("t2_emitted", m_emitted, 20);
      chk("t2_done_cnt", m_done_cnt, 1);
      $display("txn t2: W 20 blocks, beats=%0d emitted=%0d", beat_idx, m_emitted);

      // X stream, 130 blocks with random backpressure
      sel = 1'b0;
      fill_random(3);
      n_offer = 3; m_done_cnt = 0;
      step(1'b1, 32'd130, 1'b0, 1'b1);
      run(2000, 1'b1);
      chk("t3_beats", beat_idx, 3);
      chk("t3_emitted", m_emitted, 130);
      chk("t3_done_cnt", m_done_cnt, 1);
      $display("txn t3: X 130 blocks backpressured, emitted=%0d", m_emitted);

      // zero-block job
      fill_random(1);
      n_offer = 1; m_done_cnt = 0; beat_idx = 0;
      step(1'b1, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t4_done_cnt", m_done_cnt, 1);
      $display("txn t4: zero-block job, done pulses=%0d", m_done_cnt);

      // clear after 5 of 40, then a fresh 3-block job
      fill_random(1);
      n_offer = 1; m_done_cnt = 0;
      step(1'b1, 32'd40, 1'b0, 1'b1);
      for (int i = 0; i < 20 && m_emitted < 5; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t5_pre_clear", m_emitted, 5);
      step(1'b0, 32'd0, 1'b1, 1'b1);
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t5_clr_data", o_edata, 0);
      chk("t5_clr_last", o_elast, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t5_no_done", m_done_cnt, 0);
      fill_random(1);
      n_offer = 1;
      step(1'b1, 32'd3, 1'b0, 1'b1);
      run(20, 1'b0);
      chk("t5_restart_emitted", m_emitted, 3);
      chk("t5_restart_done", m_done_cnt, 1);
      $display("txn t5: clear mid-job then 3-block job, emitted=%0d", m_emitted);

      // start pulsed while active is ignored
      sel = 1'b1;
      fill_random(2);
      n_offer = 2; m_done_cnt = 0;
      step(1'b1, 32'd20, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 32'd99, 1'b0, 1'b1);
      run(200, 1'b1);
      chk("t6_emitted", m_emitted, 20);
      chk("t6_done_cnt", m_done_cnt, 1);
      $display("txn t6: restart ignored, emitted=%0d", m_emitted);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/redmule_mx_exp_unpacker.md
Name: redmule_mx_exp_unpacker

Overview:
Receive end of the MX exponent streams. The memory scheduler issues the X/W exponent source streams as linear runs of 64-byte beats. This block consumes those beats through a valid/ready handshake and unpacks each beat into one shared exponent per MX block: 1 byte per block for X (LANES=1) or a 4-byte vector exponent for W (LANES=4). The unpacked exponents are presented on a valid/ready output port to the MX decode path. One instance is used per exponent stream.

Parameters:
BEAT_W, 512, width of one exponent stream beat in bits (64 bytes)
EXP_W, 8, width of one exponent in bits
LANES, 1, exponents per MX block (1 for X, 4 for W)
SLOTS, BEAT_W/(LANES*EXP_W), localparam: blocks per beat (64 for X, 16 for W)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous abort/clear
start_i  in  1  single-cycle job start
num_blocks_i  in  32  number of MX blocks in the job, sampled on start_i
beat_valid_i  in  1  exponent beat valid
beat_ready_o  out  1  exponent beat accepted
beat_data_i  in  BEAT_W  exponent beat; byte 0 in bits [7:0]
exp_valid_o  out  1  block exponent valid
exp_ready_i  in  1  downstream ready
exp_data_o  out  LANES*EXP_W  exponent(s) of the current block
exp_last_o  out  1  current exponent belongs to the final block of the job
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse at job completion

Behaviour:
- Reset/clear values: all outputs 0. FSM in IDLE, beat buffer empty, all counters 0.
- Clock/reset: clk_i rising edge; rst_ni asynchronous, active-low.
- FSM states:
  - IDLE: start_i with num_blocks_i!=0 loads fetch_left=num_blocks_i and emit_left=num_blocks_i, then goes to ACTIVE. start_i with num_blocks_i==0 stays in IDLE and pulses done_o on the next cycle.
  - ACTIVE: beats are fetched and exponents emitted. When the last block fires, go to IDLE and pulse done_o in the following cycle.
- start_i outside IDLE is ignored.
- busy_o = (state==ACTIVE).
- Beat buffer: single entry, holding buf_data, buf_cnt (valid slots) and slot (read index).
- Beat acceptance:
  - beat_ready_o = ACTIVE && fetch_left!=0 && (!buf_valid || (exp_fire && slot==buf_cnt-1)).
  - This allows back-to-back beats with no bubble.
- On beat fire:
  - buf_data <= beat_data_i
  - buf_cnt <= min(SLOTS, fetch_left)
  - fetch_left -= that count
  - slot <= 0
- Beats are never accepted once fetch_left==0. Extra upstream beats stay pending and are flushed only by clear_i.
- Output port:
  - exp_valid_o = buf_valid.
  - exp_data_o = buf_data[slot*LANES*EXP_W +: LANES*EXP_W], with slot 0 in the LSBs.
  - exp_last_o = buf_valid && emit_left==1.
  - Data and last are stable while valid && !ready.
- On exp fire (valid&&ready): emit_left -= 1. If slot==buf_cnt-1, the buffer empties (unless refilled the same cycle); otherwise slot += 1. Slots beyond buf_cnt in the final beat are discarded.
- Latency: a beat accepted in cycle t gives first exp_valid_o in cycle t+1. Throughput is 1 exponent per cycle.
- Simultaneous refill and drain of the last slot: the new beat wins, buffer stays valid, slot=0.
- clear_i (any state, including mid-beat): next cycle is IDLE with buffer dropped, no done_o pulse, and beat_ready_o=0. clear_i has priority over start_i.
- Counters are 32-bit unsigned. min() is computed as a 32-bit compare against SLOTS; no wrap is possible.

Test Plan:
- LANES=1, num_blocks=8 (M=K=16), one beat with bytes 0x10..0x4F: exactly 1 beat accepted, then 8 exponents 0x10..0x17 in 8 consecutive cycles. exp_last_o on 0x17, done_o one cycle later, busy_o low.
- LANES=4, num_blocks=20, two beats: exponents 0..15 come from beat 0 words 0..15 and 16..19 from beat 1 words 0..3. beat_ready_o asserts on the same cycle slot 15 fires, with no gap in exp_valid_o. A third offered beat is never accepted.
- Backpressure: exp_ready_i toggled randomly, 130 blocks with LANES=1: all 130 exponents delivered in order, data stable while stalled, beat_ready_o never high while 2+ unread slots remain.
- num_blocks=0 start: no beat accepted, busy_o stays 0, done_o pulses exactly once on the next cycle.
- clear_i asserted after 5 of 40 exponents: outputs 0 next cycle, no done_o. A fresh start with num_blocks=3 then completes normally.
- start_i pulsed again while ACTIVE with num_blocks=99: ignored; the original job completes with its original count.
